// File: rtl/pwm_gate_guard_pkg.sv
// Shared types and constants for the three-phase gate-drive guard.
// Leg states, trip cause codes and the default counter width.
package pwm_gate_guard_pkg;

  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HI_ON = 2'd1,
    LO_ON = 2'd2
  } leg_state_t;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_EXT  = 2'b01;
  localparam logic [1:0] CAUSE_SOFT = 2'b10;
  localparam logic [1:0] CAUSE_BOTH = 2'b11;

endpackage

// File: rtl/pwm_gate_leg.sv
// One inverter leg: a dead-gap enforcing FSM that decodes directly to the gate pins,
// plus a sticky flag for simultaneous high/low requests.
module pwm_gate_leg
  import pwm_gate_guard_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             force_idle,
  input  logic             pwm_hi,
  input  logic             pwm_lo,
  input  logic [CNT_W-1:0] min_dead,
  input  logic             st_clear,
  output logic             gate_h,
  output logic             gate_l,
  output logic             st_err
);

  leg_state_t       state_reg;
  leg_state_t       state_next;
  logic [CNT_W-1:0] dcnt_reg;
  logic             st_err_reg;
  logic             rh;
  logic             rl;
  logic             dead_ok;

  assign rh      = pwm_hi & ~pwm_lo;
  assign rl      = pwm_lo & ~pwm_hi;
  assign dead_ok = (dcnt_reg >= min_dead);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Only IDLE can reach either on-state, so a side change always passes through the dead gap.
  always_comb begin
    state_next = state_reg;
    if (force_idle) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (rh && dead_ok) begin
            state_next = HI_ON;
          end else if (rl && dead_ok) begin
            state_next = LO_ON;
          end
        end
        HI_ON:   if (!rh) state_next = IDLE;
        LO_ON:   if (!rl) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    gate_h = (state_reg == HI_ON);
    gate_l = (state_reg == LO_ON);
  end

  // Held at zero while a gate is on, so it reads zero on the first IDLE cycle.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      dcnt_reg <= '0;
    end else if (state_reg == IDLE) begin
      if (dcnt_reg != {CNT_W{1'b1}}) begin
        dcnt_reg <= dcnt_reg + 1'b1;
      end
    end else begin
      dcnt_reg <= '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      st_err_reg <= 1'b0;
    end else if (pwm_hi && pwm_lo) begin
      st_err_reg <= 1'b1;
    end else if (st_clear) begin
      st_err_reg <= 1'b0;
    end
  end

  assign st_err = st_err_reg;

endmodule

// File: rtl/pwm_gate_guard.sv
// Gate-drive guard: three dead-gap legs plus a filtered fault / soft trip latch
// that holds all gates low until a qualified clear.
module pwm_gate_guard
  import pwm_gate_guard_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Enable,
  input  logic [2:0]       PWM_Hi,
  input  logic [2:0]       PWM_Lo,
  input  logic [CNT_W-1:0] MinDead,
  input  logic [CNT_W-1:0] Fault_Filter,
  input  logic             Fault_n,
  input  logic             Soft_Trip,
  input  logic             Trip_Clear,
  output logic [2:0]       Gate_H,
  output logic [2:0]       Gate_L,
  output logic             Tripped,
  output logic [1:0]       Trip_Cause,
  output logic [2:0]       ST_Err
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   fs;
  logic [CNT_W-1:0]       filt_cnt_reg;
  logic                   ext_fault;
  logic                   trip_now;
  logic                   clear_ok;
  logic                   force_idle;
  logic                   tripped_reg;
  logic [1:0]             cause_reg;
  logic [1:0]             cause_next;

  // Flops preset to 1 so a reset never looks like a fault.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      sync_reg <= {SYNC_STAGES{1'b1}};
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], Fault_n};
    end
  end

  assign fs = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge Clk) begin
    if (!Reset_n || fs) begin
      filt_cnt_reg <= '0;
    end else if (filt_cnt_reg != {CNT_W{1'b1}}) begin
      filt_cnt_reg <= filt_cnt_reg + 1'b1;
    end
  end

  assign ext_fault  = !fs && (filt_cnt_reg >= Fault_Filter);
  assign trip_now   = ext_fault | Soft_Trip;
  // A clear can only succeed when no trip source is active in the same cycle.
  assign clear_ok   = Trip_Clear && fs && !Soft_Trip;
  assign force_idle = !Enable || tripped_reg || trip_now;

  always_comb begin
    cause_next = CAUSE_NONE;
    case ({ext_fault, Soft_Trip})
      2'b10:   cause_next = CAUSE_EXT;
      2'b01:   cause_next = CAUSE_SOFT;
      2'b11:   cause_next = CAUSE_BOTH;
      default: cause_next = CAUSE_NONE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      tripped_reg <= 1'b0;
      cause_reg   <= CAUSE_NONE;
    end else if (!tripped_reg && trip_now) begin
      tripped_reg <= 1'b1;
      cause_reg   <= cause_next;
    end else if (clear_ok) begin
      tripped_reg <= 1'b0;
      cause_reg   <= CAUSE_NONE;
    end
  end

  assign Tripped    = tripped_reg;
  assign Trip_Cause = cause_reg;

  for (genvar gi = 0; gi < 3; gi++) begin : g_leg
    pwm_gate_leg #(
      .CNT_W (CNT_W)
    ) u_leg (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .force_idle (force_idle),
      .pwm_hi     (PWM_Hi[gi]),
      .pwm_lo     (PWM_Lo[gi]),
      .min_dead   (MinDead),
      .st_clear   (clear_ok),
      .gate_h     (Gate_H[gi]),
      .gate_l     (Gate_L[gi]),
      .st_err     (ST_Err[gi])
    );
  end

endmodule

// File: tb/tb_pwm_gate_guard.sv
// Directed bench for pwm_gate_guard: stimulus queues expected output snapshots
// tagged with a cycle number, a negedge monitor pops and compares them.
module tb_pwm_gate_guard;

  localparam int CNT_W = 16;

  logic             Clk = 1'b0;
  logic             Reset_n;
  logic             Enable;
  logic [2:0]       PWM_Hi;
  logic [2:0]       PWM_Lo;
  logic [CNT_W-1:0] MinDead;
  logic [CNT_W-1:0] Fault_Filter;
  logic             Fault_n;
  logic             Soft_Trip;
  logic             Trip_Clear;
  logic [2:0]       Gate_H;
  logic [2:0]       Gate_L;
  logic             Tripped;
  logic [1:0]       Trip_Cause;
  logic [2:0]       ST_Err;

  pwm_gate_guard #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .Enable       (Enable),
    .PWM_Hi       (PWM_Hi),
    .PWM_Lo       (PWM_Lo),
    .MinDead      (MinDead),
    .Fault_Filter (Fault_Filter),
    .Fault_n      (Fault_n),
    .Soft_Trip    (Soft_Trip),
    .Trip_Clear   (Trip_Clear),
    .Gate_H       (Gate_H),
    .Gate_L       (Gate_L),
    .Tripped      (Tripped),
    .Trip_Cause   (Trip_Cause),
    .ST_Err       (ST_Err)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int         cyc;
    string      nm;
    logic [11:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc_cnt = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge Clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: compare every queued snapshot that falls due on this cycle.
  always @(negedge Clk) begin
    logic [11:0] act;
    int i;
    act = {Gate_H, Gate_L, ST_Err, Tripped, Trip_Cause};
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc <= cyc_cnt) begin
        n_checks++;
        if (sb[i].cyc < cyc_cnt || act !== sb[i].val) begin
          n_fail++;
          $display("FAIL %s cyc=%0d got H=%b L=%b st=%b tr=%b cause=%b want H=%b L=%b st=%b tr=%b cause=%b",
                   sb[i].nm, cyc_cnt, act[11:9], act[8:6], act[5:3], act[2], act[1:0],
                   sb[i].val[11:9], sb[i].val[8:6], sb[i].val[5:3], sb[i].val[2], sb[i].val[1:0]);
        end else begin
          $display("check %s cyc=%0d H=%b L=%b st=%b tr=%b cause=%b ok",
                   sb[i].nm, cyc_cnt, act[11:9], act[8:6], act[5:3], act[2], act[1:0]);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Expected state after the d-th upcoming clock edge.
  task automatic exp_at(input int d, input string nm, input logic [2:0] gh, input logic [2:0] gl,
                        input logic [2:0] st, input logic tr, input logic [1:0] cs);
    exp_t e;
    e.cyc = cyc_cnt + d;
    e.nm  = nm;
    e.val = {gh, gl, st, tr, cs};
    sb.push_back(e);
  endtask

  initial begin
    Reset_n = 1'b0; Enable = 1'b0; PWM_Hi = '0; PWM_Lo = '0;
    MinDead = 16'd3; Fault_Filter = 16'd4; Fault_n = 1'b1;
    Soft_Trip = 1'b0; Trip_Clear = 1'b0;
    tick(2);
    exp_at(1, "reset", 3'b000, 3'b000, 3'b000, 1'b0, 2'b00);
    tick(1);
    Reset_n = 1'b1; Enable = 1'b1;
    tick(4);

    // Dead gap on a high-to-low swap with MinDead=3
    PWM_Hi = 3'b001;
    exp_at(1, "t1_hi_on", 3'b001, 3'b000, 3'b000, 1'b0, 2'b00);
    tick(1);
    PWM_Hi = 3'b000; PWM_Lo = 3'b001;
    exp_at(1, "t1_hi_fall", 3'b000, 3'b000, 3'b000, 1'b0, 2'b00);
    exp_at(4, "t1_gap_end", 3'b000, 3'b000, 3'b000, 1'b0, 2'b00);
    exp_at(5, "t1_lo_rise", 3'b000, 3'b001, 3'b000, 1'b0, 2'b00);
    tick(5);

    // MinDead=0 still leaves a one-cycle gap
    MinDead = 16'd0; PWM_Lo = 3'b000; PWM_Hi = 3'b001;
    exp_at(1, "md0_fall", 3'b000, 3'b000, 3'b000, 1'b0, 2'b00);
    exp_at(2, "md0_rise", 3'b001, 3'b000, 3'b000, 1'b0, 2'b00);
    tick(2);

    // Same-side re-request also waits out the gap
    MinDead = 16'd2; PWM_Hi = 3'b000;
    exp_at(1, "rereq_off", 3'b000, 3'b000, 3'b000, 1'b0, 2'b00);
    tick(1);
    PWM_Hi = 3'b001;
    exp_at(2, "rereq_gap", 3'b000, 3'b000, 3'b000, 1'b0, 2'b00);
    exp_at(3, "rereq_on", 3'b001, 3'b000, 3'b000, 1'b0, 2'b00);
    tick(3);

    // Shoot-through request on phase 1
    PWM_Hi = 3'b011; PWM_Lo = 3'b010;
    exp_at(1, "st_set", 3'b001, 3'b000, 3'b010, 1'b0, 2'b00);
    exp_at(2, "st_hold", 3'b001, 3'b000, 3'b010, 1'b0, 2'b00);
    tick(2);
    PWM_Hi = 3'b001; PWM_Lo = 3'b000; Trip_Clear = 1'b1;
    exp_at(1, "st_clear", 3'b001, 3'b000, 3'b000, 1'b0, 2'b00);
    tick(1);
    Trip_Clear = 1'b0;

    // Short fault burst below the filter length
    Fault_n = 1'b0;
    exp_at(1, "flt_short_a", 3'b001, 3'b000, 3'b000, 1'b0, 2'b00);
    tick(3);
    Fault_n = 1'b1;
    exp_at(3, "flt_short_b", 3'b001, 3'b000, 3'b000, 1'b0, 2'b00);
    exp_at(6, "flt_short_c", 3'b001, 3'b000, 3'b000, 1'b0, 2'b00);
    tick(6);

    // Held fault trips after sync (2) + filter (4)
    Fault_n = 1'b0;
    exp_at(6, "flt_pre", 3'b001, 3'b000, 3'b000, 1'b0, 2'b00);
    exp_at(7, "flt_trip", 3'b000, 3'b000, 3'b000, 1'b1, 2'b01);
    tick(7);

    // Clear ignored while the fault persists
    Trip_Clear = 1'b1;
    exp_at(1, "clr_ignored", 3'b000, 3'b000, 3'b000, 1'b1, 2'b01);
    tick(1);
    Trip_Clear = 1'b0;
    Fault_n = 1'b1;
    tick(2);
    Trip_Clear = 1'b1;
    exp_at(1, "ext_clear", 3'b000, 3'b000, 3'b000, 1'b0, 2'b00);
    tick(1);
    Trip_Clear = 1'b0;
    exp_at(1, "ext_resume", 3'b001, 3'b000, 3'b000, 1'b0, 2'b00);
    tick(1);

    // Soft trip while phases toggle
    MinDead = 16'd0; PWM_Lo = 3'b100;
    exp_at(1, "tog", 3'b001, 3'b100, 3'b000, 1'b0, 2'b00);
    tick(1);
    PWM_Hi = 3'b010; Soft_Trip = 1'b1;
    exp_at(1, "soft_trip", 3'b000, 3'b000, 3'b000, 1'b1, 2'b10);
    tick(1);
    Soft_Trip = 1'b0;
    exp_at(1, "soft_hold", 3'b000, 3'b000, 3'b000, 1'b1, 2'b10);
    tick(1);
    Trip_Clear = 1'b1;
    exp_at(1, "soft_clear", 3'b000, 3'b000, 3'b000, 1'b0, 2'b00);
    tick(1);
    Trip_Clear = 1'b0;
    exp_at(1, "soft_resume", 3'b010, 3'b100, 3'b000, 1'b0, 2'b00);
    tick(1);

    // Clear and soft trip together: trip wins
    Trip_Clear = 1'b1; Soft_Trip = 1'b1;
    exp_at(1, "clr_vs_soft", 3'b000, 3'b000, 3'b000, 1'b1, 2'b10);
    tick(1);
    Soft_Trip = 1'b0;
    exp_at(1, "clr_after", 3'b000, 3'b000, 3'b000, 1'b0, 2'b00);
    tick(1);
    Trip_Clear = 1'b0;
    exp_at(1, "resume2", 3'b010, 3'b100, 3'b000, 1'b0, 2'b00);
    tick(1);

    // External and soft in the same cycle; Fault_Filter=0 trips on first synced low
    Fault_Filter = 16'd0; Fault_n = 1'b0;
    exp_at(2, "both_pre", 3'b010, 3'b100, 3'b000, 1'b0, 2'b00);
    tick(2);
    Soft_Trip = 1'b1;
    exp_at(1, "both_trip", 3'b000, 3'b000, 3'b000, 1'b1, 2'b11);
    tick(1);
    exp_at(1, "cause_keep", 3'b000, 3'b000, 3'b000, 1'b1, 2'b11);
    tick(1);
    Soft_Trip = 1'b0;
    PWM_Hi = 3'b101; PWM_Lo = 3'b001;
    exp_at(1, "st_tripped", 3'b000, 3'b000, 3'b001, 1'b1, 2'b11);
    tick(1);

    // One-cycle reset, then dead gap of MinDead=2 from reset
    Reset_n = 1'b0; MinDead = 16'd2; PWM_Hi = 3'b100; PWM_Lo = 3'b000;
    Fault_n = 1'b1; Fault_Filter = 16'd4;
    exp_at(1, "rst_mid", 3'b000, 3'b000, 3'b000, 1'b0, 2'b00);
    tick(1);
    Reset_n = 1'b1;
    exp_at(2, "rst_gap", 3'b000, 3'b000, 3'b000, 1'b0, 2'b00);
    exp_at(3, "rst_hi", 3'b100, 3'b000, 3'b000, 1'b0, 2'b00);
    tick(3);

    // Enable low forces idle while the dead counter keeps running
    Enable = 1'b0;
    exp_at(1, "en_off", 3'b000, 3'b000, 3'b000, 1'b0, 2'b00);
    exp_at(3, "en_off_hold", 3'b000, 3'b000, 3'b000, 1'b0, 2'b00);
    tick(3);
    Enable = 1'b1;
    exp_at(1, "en_on", 3'b100, 3'b000, 3'b000, 1'b0, 2'b00);
    tick(1);

    for (int w = 0; w < 20 && sb.size() != 0; w++) tick(1);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_gate_guard.md
Name: pwm_gate_guard

Overview:
Gate-drive guard stage that sits directly downstream of the three-phase PWM generator. It takes the generator's high-side and low-side requests per phase and enforces a minimum dead gap between complementary gates, rejecting shoot-through requests. It also latches a trip from a filtered external fault pin or a software trip, holding all gates low until a qualified clear. Its outputs drive the inverter gate-driver pins directly.

Parameters:
CNT_W, 16, width of the dead-time and fault-filter counters and their configuration ports.
SYNC_STAGES, 2, number of flip-flop stages synchronising Fault_n (minimum 2).

Ports:
Clk  input  1  system clock; the only clock.
Reset_n  input  1  reset, synchronous, active-low.
Enable  input  1  1 = gates may follow requests; 0 = all gates low.
PWM_Hi  input  3  high-side requests, one bit per phase, from the PWM generator.
PWM_Lo  input  3  low-side requests, one bit per phase, from the PWM generator.
MinDead  input  CNT_W  minimum dead gap in clocks; sampled every cycle.
Fault_Filter  input  CNT_W  number of consecutive low cycles required to qualify a fault.
Fault_n  input  1  external driver fault, asynchronous, active-low.
Soft_Trip  input  1  single-cycle software trip request.
Trip_Clear  input  1  single-cycle request to clear the trip and the ST_Err flags.
Gate_H  output  3  high-side gate drive, registered.
Gate_L  output  3  low-side gate drive, registered.
Tripped  output  1  latched trip status.
Trip_Cause  output  2  first cause: 00 none, 01 external, 10 soft, 11 both in the same cycle.
ST_Err  output  3  sticky per-phase flag: both requests were seen high together.

Behaviour:
- Reset (Reset_n=0 at an edge):
  - Gate_H, Gate_L, ST_Err = 0; Tripped = 0; Trip_Cause = 00.
  - Every leg goes to IDLE with its dead counter = 0; the fault filter counter = 0; the synchroniser flops = 1.
- Leg FSM, one instance per phase. States: IDLE, HI_ON, LO_ON.
  - Gate outputs decode the state: HI_ON gives Gate_H=1; LO_ON gives Gate_L=1; IDLE gives both 0.
  - Gate_H and Gate_L are never both 1.
- Dead counter dcnt (CNT_W bits):
  - Set to 0 on every edge that enters IDLE.
  - Increments on each edge spent in IDLE and saturates at all-ones.
- Effective requests: rh = PWM_Hi & ~PWM_Lo; rl = PWM_Lo & ~PWM_Hi.
  - When PWM_Hi and PWM_Lo are both 1 for a phase, rh = rl = 0 and ST_Err[phase] is set.
- Transitions (evaluated only when Enable=1 and Tripped=0):
  - IDLE to HI_ON when rh=1 and dcnt >= MinDead.
  - IDLE to LO_ON when rl=1 and dcnt >= MinDead.
  - HI_ON to IDLE when rh=0.
  - LO_ON to IDLE when rl=0.
  - No direct HI_ON to LO_ON or LO_ON to HI_ON path exists.
- Timing:
  - If one gate falls at edge k, the opposite gate rises no earlier than edge k+MinDead+1.
  - With MinDead=0 the gap is 1 cycle.
  - Latency from a request change to a gate change is 1 clock when the dead constraint is already met.
  - The dead gap also applies when the same side is re-requested.
- Enable=0 or Tripped=1: every leg is forced to IDLE on that edge, so gates go low the next cycle. dcnt keeps counting, so the dead gap is already satisfied on exit.
- Fault path:
  - Fault_n passes through SYNC_STAGES flops to give fs.
  - The filter counter increments while fs=0, saturating, and resets to 0 when fs=1.
  - The fault qualifies when fs=0 and the counter >= Fault_Filter. Fault_Filter=0 qualifies on the first synchronised low.
- Trip:
  - On the edge where a qualified fault or Soft_Trip is present and Tripped=0: Tripped<=1, and Trip_Cause<=01, 10 or 11 as appropriate.
  - Legs go IDLE on that same edge, so gates are low one clock after the trip condition is seen.
  - Later causes never overwrite Trip_Cause.
- Clear:
  - Trip_Clear clears Tripped, Trip_Cause and ST_Err only if fs=1 and Soft_Trip=0 on that cycle; otherwise it is ignored.
  - When Trip_Clear and a trip source coincide, the trip wins.
  - ST_Err is cleared by Trip_Clear even when Tripped=0.
- A change of MinDead mid-gap takes effect immediately in the comparison.
- Widths: all comparisons are unsigned CNT_W; counters saturate and never wrap.

Decomposition:
- pwm_gate_guard_pkg holds: the leg state enum (IDLE, HI_ON, LO_ON); the Trip_Cause codes (CAUSE_NONE, CAUSE_EXT, CAUSE_SOFT, CAUSE_BOTH); and the default CNT_W.
- One sub-module, pwm_gate_leg, contains the leg FSM, dcnt and the ST_Err bit. It is instantiated three times.
- The fault synchroniser, filter and trip latch stay in the top level.

Test Plan:
1. MinDead=3, Enable=1, PWM_Hi[0] falls at edge k with PWM_Lo[0] rising on the same edge -> Gate_H[0] falls at k+1 and Gate_L[0] rises at k+5 (gap of MinDead+1 cycles, measured from the gate fall at k+1).
2. PWM_Hi[1]=PWM_Lo[1]=1 for 2 cycles -> Gate_H[1]=Gate_L[1]=0 and ST_Err=3'b010; a Trip_Clear pulse afterwards returns ST_Err to 000.
3. Fault_Filter=4; Fault_n low for 3 cycles, then high -> no trip. Fault_n held low -> Tripped=1 and Trip_Cause=01 at 2+4 cycles after the first sync-stage sample, with all gates 0 one clock later.
4. Soft_Trip pulse while phases are toggling -> Tripped=1, Trip_Cause=10; Trip_Clear with Fault_n=1 -> Tripped=0, and gates resume on the next request with no extra dead gap.
5. Trip_Clear issued while Fault_n is still low -> Tripped stays 1 and Trip_Cause stays unchanged.
6. Reset_n=0 for 1 cycle mid-pulse with MinDead=2 -> all outputs 0; after release, a held PWM_Hi[2] produces Gate_H[2]=1 no earlier than 3 clocks later.
